// File: rtl/ifu_pkg.sv
// Shared fetch-unit types and constants.
package ifu_pkg;

  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  // The queue entry holds the widest supported PC; narrower configurations use the low bits.
  localparam int unsigned MAX_XLEN    = 64;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [ILEN-1:0]     instr;
    logic                filled;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Reservation queue: entries are allocated at request time and filled in response order.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_alloc_pc,
  input  logic            i_fill,
  input  logic [ILEN-1:0] i_fill_instr,
  input  logic            i_pop,
  input  logic            i_flush,
  output logic            o_head_filled,
  output logic [XLEN-1:0] o_head_pc,
  output logic [ILEN-1:0] o_head_instr,
  output logic [CW-1:0]   o_occupancy,
  output logic [CW-1:0]   o_unfilled
);

  fetch_entry_t  r_mem [DEPTH];
  logic [CW-1:0] r_head;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_tail;

  logic [PW-1:0] w_head_idx;
  logic [PW-1:0] w_fill_idx;
  logic [PW-1:0] w_tail_idx;
  fetch_entry_t  w_head;

  assign w_head_idx = r_head[PW-1:0];
  assign w_fill_idx = r_fill[PW-1:0];
  assign w_tail_idx = r_tail[PW-1:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_fill <= '0;
      r_tail <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_head <= '0;
      r_fill <= '0;
      r_tail <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i].filled <= 1'b0;
      end
    end else begin
      if (i_alloc) begin
        r_mem[w_tail_idx].pc     <= MAX_XLEN'(i_alloc_pc);
        r_mem[w_tail_idx].filled <= 1'b0;
        r_tail                   <= r_tail + 1'b1;
      end
      if (i_fill) begin
        r_mem[w_fill_idx].instr  <= i_fill_instr;
        r_mem[w_fill_idx].filled <= 1'b1;
        r_fill                   <= r_fill + 1'b1;
      end
      if (i_pop) begin
        r_mem[w_head_idx].filled <= 1'b0;
        r_head                   <= r_head + 1'b1;
      end
    end
  end

  assign w_head        = r_mem[w_head_idx];
  assign o_head_filled = w_head.filled;
  assign o_head_pc     = w_head.pc[XLEN-1:0];
  assign o_head_instr  = w_head.instr;
  assign o_occupancy   = r_tail - r_head;
  assign o_unfilled    = r_tail - r_fill;

  if (XLEN < MAX_XLEN) begin : g_pc_upper
    logic w_unused_pc_upper;
    assign w_unused_pc_upper = ^w_head.pc[MAX_XLEN-1:XLEN];
  end

endmodule

// File: rtl/ifu_fetch_pipe.sv
// Instruction-fetch unit: PC, request credit, stale-response discard and the decode-side queue.
module ifu_fetch_pipe
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr
);

  localparam int unsigned   CW        = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FQ_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_discard;

  logic            w_req_fire;
  logic            w_alloc;
  logic            w_fill;
  logic            w_pop;
  logic            w_head_filled;
  logic [CW-1:0]   w_occ;
  logic [CW-1:0]   w_unfilled;
  logic [CW-1:0]   w_credit_used;
  logic [CW-1:0]   w_discard_redirect;
  logic            w_unused_redirect_lsb;

  // occupancy + discard never exceeds FQ_DEPTH, so CW bits hold the sum.
  assign w_credit_used  = w_occ + r_discard;
  assign imem_req_valid = (w_credit_used < DEPTH_CNT) && !rst;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_alloc = w_req_fire && !redirect_valid;
  assign w_fill  = imem_rsp_valid && (r_discard == '0) && !redirect_valid;

  assign id_valid = w_head_filled && !redirect_valid;
  assign w_pop    = id_valid && id_ready;

  // Everything still owed by memory after a flush becomes a response to throw away.
  assign w_discard_redirect = r_discard + w_unfilled + CW'(w_req_fire) - CW'(imem_rsp_valid);

  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_discard <= '0;
    end else if (redirect_valid) begin
      r_pc      <= {redirect_pc[XLEN-1:2], 2'b00};
      r_discard <= w_discard_redirect;
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + XLEN'(INSTR_BYTES);
      end
      if (imem_rsp_valid && (r_discard != '0)) begin
        r_discard <= r_discard - 1'b1;
      end
    end
  end

  ifu_fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .i_alloc       (w_alloc),
    .i_alloc_pc    (r_pc),
    .i_fill        (w_fill),
    .i_fill_instr  (imem_rsp_data),
    .i_pop         (w_pop),
    .i_flush       (redirect_valid),
    .o_head_filled (w_head_filled),
    .o_head_pc     (id_pc),
    .o_head_instr  (id_instr),
    .o_occupancy   (w_occ),
    .o_unfilled    (w_unfilled)
  );

endmodule

// File: tb/tb_ifu_fetch_pipe.sv
// Directed bench for ifu_fetch_pipe with an in-order, fixed-latency memory model.
module tb_ifu_fetch_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned Depth = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          lat     = 1;
  logic [31:0] exp_pc  = '0;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  always #5 clk = ~clk;

  ifu_fetch_pipe #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present this cycle's memory response, then let combinational outputs settle.
  task automatic drive();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq_addr[0] ^ 32'hA5A5_0000;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
  endtask

  // Record handshakes and decode pops for this cycle, then advance one clock.
  task automatic tick();
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
    end
    if (!rst) chk("outstanding_le_depth", 32'(mq_addr.size() <= int'(Depth)), 32'd1);
    if (id_valid && id_ready) begin
      chk("stream_pc", id_pc, exp_pc);
      chk("stream_instr", id_instr, exp_pc ^ 32'hA5A5_0000);
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    exp_pc = '0;
    for (int i = 0; i < ncyc; i++) begin
      drive();
      tick();
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_instr", id_instr, 32'd0);
      tick();
    end
    rst      = 1'b0;
    cyc      = 0;
    id_ready = 1'b1;

    // Streaming with single-cycle memory.
    drive();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    chk("first_id_valid", 32'(id_valid), 32'd0);
    tick();
    drive();
    chk("fill_id_valid", 32'(id_valid), 32'd0);
    chk("second_req_addr", imem_req_addr, 32'h4);
    tick();
    for (int k = 2; k < 10; k++) begin
      drive();
      chk("stream_valid", 32'(id_valid), 32'd1);
      chk("stream_head_pc", id_pc, 32'(4 * (k - 2)));
      chk("stream_req_addr", imem_req_addr, 32'(4 * k));
      tick();
    end

    // Backpressure: decode stalled, queue fills to FQ_DEPTH.
    id_ready = 1'b0;
    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      drive();
      chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("bp_req_addr", imem_req_addr, 32'(4 * k));
      tick();
    end
    for (int k = 4; k < 6; k++) begin
      drive();
      chk("bp_full_req_valid", 32'(imem_req_valid), 32'd0);
      chk("bp_head_valid", 32'(id_valid), 32'd1);
      chk("bp_head_pc", id_pc, 32'h0);
      tick();
    end
    id_ready = 1'b1;
    drive();
    chk("bp_release_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    drive();
    chk("bp_resume_req_valid", 32'(imem_req_valid), 32'd1);
    chk("bp_resume_addr", imem_req_addr, 32'h10);
    tick();
    drive(); tick();
    drive(); tick();
    drive();
    chk("bp_after_drain_pc", id_pc, 32'h10);
    tick();

    // Redirect with two outstanding requests, memory latency 3.
    do_reset(2);
    lat = 3;
    drive(); tick();
    drive(); tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    drive();
    chk("redir_id_valid", 32'(id_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    drive();
    chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    chk("redir_stale0_id_valid", 32'(id_valid), 32'd0);
    tick();
    drive();
    chk("redir_stale1_id_valid", 32'(id_valid), 32'd0);
    tick();
    drive(); tick();
    drive();
    chk("redir_wait_id_valid", 32'(id_valid), 32'd0);
    tick();
    drive();
    chk("redir_first_valid", 32'(id_valid), 32'd1);
    chk("redir_first_pc", id_pc, 32'h100);
    chk("redir_first_instr", id_instr, 32'hA5A5_0100);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(); tick();
    end

    // Redirect coinciding with a request handshake and a response.
    do_reset(2);
    lat = 1;
    drive(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    drive();
    chk("same_cyc_rsp_present", 32'(imem_rsp_valid), 32'd1);
    chk("same_cyc_req_valid", 32'(imem_req_valid), 32'd1);
    tick();
    redirect_valid = 1'b0;
    drive();
    chk("same_cyc_new_addr", imem_req_addr, 32'h200);
    chk("same_cyc_drop_id_valid", 32'(id_valid), 32'd0);
    tick();
    drive();
    chk("same_cyc_fill_id_valid", 32'(id_valid), 32'd0);
    tick();
    drive();
    chk("same_cyc_first_valid", 32'(id_valid), 32'd1);
    chk("same_cyc_first_pc", id_pc, 32'h200);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    drive();
    chk("redir_masks_id_valid", 32'(id_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    drive();
    chk("second_redir_addr", imem_req_addr, 32'h300);
    chk("second_redir_id_valid", 32'(id_valid), 32'd0);
    tick();
    drive(); tick();
    drive();
    chk("second_redir_first_pc", id_pc, 32'h300);
    chk("second_redir_first_valid", 32'(id_valid), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(); tick();
    end

    // Asynchronous reset with three queued entries.
    id_ready = 1'b0;
    do_reset(2);
    drive(); tick();
    drive(); tick();
    drive(); tick();
    imem_req_ready = 1'b0;
    drive(); tick();
    drive();
    chk("pre_rst_id_valid", 32'(id_valid), 32'd1);
    chk("pre_rst_req_valid", 32'(imem_req_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_id_valid", 32'(id_valid), 32'd0);
    chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_rst_id_pc", id_pc, 32'h0);
    mq_addr.delete();
    mq_due.delete();
    exp_pc = '0;
    tick();
    rst            = 1'b0;
    cyc            = 0;
    imem_req_ready = 1'b1;
    drive();
    chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("restart_req_addr", imem_req_addr, 32'h0);
    chk("restart_id_valid", 32'(id_valid), 32'd0);
    tick();
    drive(); tick();
    drive();
    chk("restart_head_valid", 32'(id_valid), 32'd1);
    chk("restart_head_pc", id_pc, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
